ct_lsu_snoop_ctcq_issue: RTL and testbench

CT_LSU_SNOOP_CTCQ_ISSUE -- requirements
Module: ct_lsu_snoop_ctcq_issue

---
 rtl/ct_lsu_snoop_ctcq_issue.sv | 194 +++++++++++++++++++
 tb/tb_ct_lsu_snoop_ctcq_issue.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_lsu_snoop_ctcq_issue.sv
// Purpose : issues CTC queue invalidate entries (icache / TLB) one at a time,
//           picking round-robin among pending entries and reporting completion.
// Latency : request valid one cycle after selection; completion pulse is
//           combinational from the downstream done (illegal type: registered,
//           one cycle after the issue cycle).
// Backpressure: valid and payload hold steady until the target's rdy; only one
//           request is ever outstanding.
// Ports   : ctcqctrlclk/cpurst_b clock and async active-low reset;
//           ctcq_entry_* per-entry pending, type flags and packed payloads;
//           lsu_ica_inv_* / ica_lsu_inv_* icache request handshake and done;
//           lsu_tlb_inv_* / tlb_lsu_inv_* TLB request handshake and done;
//           ica_tlb_ctcq_inv_cmplt one-hot completion; ctcq_issue_busy.
module ct_lsu_snoop_ctcq_issue #(
   parameter int ENTRY_NUM = 4,
   parameter int PTAG_W    = 28,
   parameter int VA_W      = 27
) (
   input  logic                        ctcqctrlclk,
   input  logic                        cpurst_b,
   input  logic [ENTRY_NUM-1:0]        ctcq_entry_pe_req,
   input  logic [ENTRY_NUM-1:0]        ctcq_entry_icache_all_inv,
   input  logic [ENTRY_NUM-1:0]        ctcq_entry_icache_line_inv,
   input  logic [ENTRY_NUM-1:0]        ctcq_entry_tlb_all_inv,
   input  logic [ENTRY_NUM-1:0]        ctcq_entry_tlb_va_all_inv,
   input  logic [ENTRY_NUM-1:0]        ctcq_entry_tlb_asid_all_inv,
   input  logic [ENTRY_NUM-1:0]        ctcq_entry_tlb_va_asid_inv,
   input  logic [ENTRY_NUM*6-1:0]      ctcq_entry_icache_index,
   input  logic [ENTRY_NUM*PTAG_W-1:0] ctcq_entry_icache_ptag,
   input  logic [ENTRY_NUM*16-1:0]     ctcq_entry_tlb_asid,
   input  logic [ENTRY_NUM*VA_W-1:0]   ctcq_entry_tlb_va,
   output logic                        lsu_ica_inv_vld,
   output logic                        lsu_ica_inv_all,
   output logic [5:0]                  lsu_ica_inv_index,
   output logic [PTAG_W-1:0]           lsu_ica_inv_ptag,
   input  logic                        ica_lsu_inv_rdy,
   input  logic                        ica_lsu_inv_done,
   output logic                        lsu_tlb_inv_vld,
   output logic [1:0]                  lsu_tlb_inv_type,
   output logic [15:0]                 lsu_tlb_inv_asid,
   output logic [VA_W-1:0]             lsu_tlb_inv_va,
   input  logic                        tlb_lsu_inv_rdy,
   input  logic                        tlb_lsu_inv_done,
   output logic [ENTRY_NUM-1:0]        ica_tlb_ctcq_inv_cmplt,
   output logic                        ctcq_issue_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10
   } state_t;

   // Flag bit order: 0 ica_all, 1 ica_line, 2 tlb_all, 3 tlb_va_all,
   // 4 tlb_asid_all, 5 tlb_va_asid.
   logic [5:0]        ent_flags [ENTRY_NUM];
   logic [5:0]        ent_index [ENTRY_NUM];
   logic [PTAG_W-1:0] ent_ptag  [ENTRY_NUM];
   logic [15:0]       ent_asid  [ENTRY_NUM];
   logic [VA_W-1:0]   ent_va    [ENTRY_NUM];

   state_t            state;
   logic [1:0]        rr_ptr;
   logic [1:0]        sel_id;
   logic [5:0]        lat_flags;
   logic [5:0]        lat_index;
   logic [PTAG_W-1:0] lat_ptag;
   logic [15:0]       lat_asid;
   logic [VA_W-1:0]   lat_va;
   logic              hold_q;       // blocks selection in the first IDLE cycle after a completion
   logic [3:0]        ill_cmplt_q;  // registered completion for an illegal-type entry

   logic              pick_vld;
   logic [1:0]        pick_id;
   logic [1:0]        cand;
   logic              tgt_ica;
   logic              tgt_tlb;
   logic              legal;
   logic [1:0]        tlb_type;
   logic              ica_vld;
   logic              tlb_vld;
   logic              handshake;
   logic              done_match;
   logic [3:0]        sel_onehot;

   // Unpack the flat per-entry buses.
   always_comb begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
         ent_flags[i] = {ctcq_entry_tlb_va_asid_inv[i], ctcq_entry_tlb_asid_all_inv[i],
                         ctcq_entry_tlb_va_all_inv[i],  ctcq_entry_tlb_all_inv[i],
                         ctcq_entry_icache_line_inv[i], ctcq_entry_icache_all_inv[i]};
         ent_index[i] = ctcq_entry_icache_index[i*6 +: 6];
         ent_ptag[i]  = ctcq_entry_icache_ptag[i*PTAG_W +: PTAG_W];
         ent_asid[i]  = ctcq_entry_tlb_asid[i*16 +: 16];
         ent_va[i]    = ctcq_entry_tlb_va[i*VA_W +: VA_W];
      end
   end

   // Round-robin: first pending entry at or above rr_ptr, wrapping mod 4.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = rr_ptr;
      cand     = rr_ptr;
      for (int k = 0; k < ENTRY_NUM; k++) begin
         cand = rr_ptr + 2'(k);
         if (!pick_vld && ctcq_entry_pe_req[cand]) begin
            pick_vld = 1'b1;
            pick_id  = cand;
         end
      end
   end

   // Icache wins over TLB when several flags are set; within TLB the lowest
   // flag index wins.
   assign tgt_ica = lat_flags[0] | lat_flags[1];
   assign tgt_tlb = ~tgt_ica & (|lat_flags[5:2]);
   assign legal   = tgt_ica | tgt_tlb;

   always_comb begin
      if (lat_flags[2])      tlb_type = 2'b00;
      else if (lat_flags[3]) tlb_type = 2'b01;
      else if (lat_flags[4]) tlb_type = 2'b10;
      else                   tlb_type = 2'b11;
   end

   assign ica_vld    = (state == ISSUE) & tgt_ica;
   assign tlb_vld    = (state == ISSUE) & tgt_tlb;
   assign handshake  = (ica_vld & ica_lsu_inv_rdy) | (tlb_vld & tlb_lsu_inv_rdy);
   assign done_match = (state == WAIT) &
                       (tgt_ica ? ica_lsu_inv_done : tlb_lsu_inv_done);
   assign sel_onehot = 4'b0001 << sel_id;

   assign lsu_ica_inv_vld   = ica_vld;
   assign lsu_ica_inv_all   = ica_vld & lat_flags[0];
   assign lsu_ica_inv_index = ica_vld ? lat_index : '0;
   assign lsu_ica_inv_ptag  = ica_vld ? lat_ptag  : '0;
   assign lsu_tlb_inv_vld   = tlb_vld;
   assign lsu_tlb_inv_type  = tlb_vld ? tlb_type : 2'b00;
   assign lsu_tlb_inv_asid  = tlb_vld ? lat_asid : '0;
   assign lsu_tlb_inv_va    = tlb_vld ? lat_va   : '0;

   assign ica_tlb_ctcq_inv_cmplt = ill_cmplt_q | (done_match ? sel_onehot : 4'b0000);
   assign ctcq_issue_busy        = (state != IDLE);

   always_ff @(posedge ctcqctrlclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state       <= IDLE;
         rr_ptr      <= 2'd0;
         sel_id      <= 2'd0;
         lat_flags   <= '0;
         lat_index   <= '0;
         lat_ptag    <= '0;
         lat_asid    <= '0;
         lat_va      <= '0;
         hold_q      <= 1'b0;
         ill_cmplt_q <= 4'b0000;
      end else begin
         hold_q      <= 1'b0;
         ill_cmplt_q <= 4'b0000;
         case (state)
            IDLE: begin
               if (!hold_q && pick_vld) begin
                  sel_id    <= pick_id;
                  lat_flags <= ent_flags[pick_id];
                  lat_index <= ent_index[pick_id];
                  lat_ptag  <= ent_ptag[pick_id];
                  lat_asid  <= ent_asid[pick_id];
                  lat_va    <= ent_va[pick_id];
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (!legal) begin
                  // Nothing to send downstream: retire the entry directly.
                  ill_cmplt_q <= sel_onehot;
                  rr_ptr      <= sel_id + 2'd1;
                  hold_q      <= 1'b1;
                  state       <= IDLE;
               end else if (handshake) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (done_match) begin
                  rr_ptr <= sel_id + 2'd1;
                  hold_q <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ct_lsu_snoop_ctcq_issue.sv
// Purpose : self-checking bench for ct_lsu_snoop_ctcq_issue.
// Latency : behavioural transaction model compared every negedge, plus
//           hand-computed literal expectations for directed scenarios.
// Backpressure: rdy/done driven directly by the directed sequences.
module tb_ct_lsu_snoop_ctcq_issue;

   logic          ctcqctrlclk = 1'b0;
   logic          cpurst_b = 1'b0;
   logic [3:0]    pe_req = '0;
   logic [3:0]    ica_all_f = '0, ica_line_f = '0;
   logic [3:0]    tlb_all_f = '0, tlb_va_all_f = '0, tlb_asid_all_f = '0, tlb_va_asid_f = '0;
   logic [23:0]   e_index = '0;
   logic [111:0]  e_ptag = '0;
   logic [63:0]   e_asid = '0;
   logic [107:0]  e_va = '0;
   logic          ica_rdy = 1'b0, ica_done = 1'b0, tlb_rdy = 1'b0, tlb_done = 1'b0;

   logic          ica_vld, ica_all;
   logic [5:0]    ica_index;
   logic [27:0]   ica_ptag;
   logic          tlb_vld;
   logic [1:0]    tlb_type;
   logic [15:0]   tlb_asid;
   logic [26:0]   tlb_va;
   logic [3:0]    cmplt;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;
   int svc[$];

   always #5 ctcqctrlclk = ~ctcqctrlclk;

   ct_lsu_snoop_ctcq_issue dut (
      .ctcqctrlclk                 (ctcqctrlclk),
      .cpurst_b                    (cpurst_b),
      .ctcq_entry_pe_req           (pe_req),
      .ctcq_entry_icache_all_inv   (ica_all_f),
      .ctcq_entry_icache_line_inv  (ica_line_f),
      .ctcq_entry_tlb_all_inv      (tlb_all_f),
      .ctcq_entry_tlb_va_all_inv   (tlb_va_all_f),
      .ctcq_entry_tlb_asid_all_inv (tlb_asid_all_f),
      .ctcq_entry_tlb_va_asid_inv  (tlb_va_asid_f),
      .ctcq_entry_icache_index     (e_index),
      .ctcq_entry_icache_ptag      (e_ptag),
      .ctcq_entry_tlb_asid         (e_asid),
      .ctcq_entry_tlb_va           (e_va),
      .lsu_ica_inv_vld             (ica_vld),
      .lsu_ica_inv_all             (ica_all),
      .lsu_ica_inv_index           (ica_index),
      .lsu_ica_inv_ptag            (ica_ptag),
      .ica_lsu_inv_rdy             (ica_rdy),
      .ica_lsu_inv_done            (ica_done),
      .lsu_tlb_inv_vld             (tlb_vld),
      .lsu_tlb_inv_type            (tlb_type),
      .lsu_tlb_inv_asid            (tlb_asid),
      .lsu_tlb_inv_va              (tlb_va),
      .tlb_lsu_inv_rdy             (tlb_rdy),
      .tlb_lsu_inv_done            (tlb_done),
      .ica_tlb_ctcq_inv_cmplt      (cmplt),
      .ctcq_issue_busy             (busy)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // phase: 0 no request, 1 request offered, 2 waiting for done
   int          m_phase = 0;
   int          m_entry = 0;
   int          m_rr = 0;
   bit          m_cool = 0;     // one idle cycle after any completion
   int          m_ill = -1;     // entry whose illegal completion shows this cycle
   bit          m_legal = 0, m_ica = 0, m_all = 0;
   logic [1:0]  m_type = '0;
   logic [5:0]  m_index = '0;
   logic [27:0] m_ptag = '0;
   logic [15:0] m_asid = '0;
   logic [26:0] m_va = '0;

   always @(posedge ctcqctrlclk) begin : model
      int ill_n;
      int e;
      ill_n = -1;
      if (!cpurst_b) begin
         m_phase = 0; m_rr = 0; m_cool = 0; m_ill = -1; m_entry = 0;
      end else begin
         if (m_phase == 0) begin
            if (m_cool) m_cool = 0;
            else if (pe_req != 0) begin
               e = -1;
               for (int k = 0; k < 4; k++)
                  if (e < 0 && pe_req[(m_rr + k) % 4]) e = (m_rr + k) % 4;
               m_entry = e;
               m_ica   = ica_all_f[e] || ica_line_f[e];
               m_all   = ica_all_f[e];
               m_legal = m_ica || tlb_all_f[e] || tlb_va_all_f[e] ||
                         tlb_asid_all_f[e] || tlb_va_asid_f[e];
               if (tlb_all_f[e])           m_type = 2'd0;
               else if (tlb_va_all_f[e])   m_type = 2'd1;
               else if (tlb_asid_all_f[e]) m_type = 2'd2;
               else                        m_type = 2'd3;
               m_index = e_index[e*6 +: 6];
               m_ptag  = e_ptag[e*28 +: 28];
               m_asid  = e_asid[e*16 +: 16];
               m_va    = e_va[e*27 +: 27];
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (!m_legal) begin
               ill_n = m_entry; m_rr = (m_entry + 1) % 4; m_cool = 1; m_phase = 0;
            end else if (m_ica ? ica_rdy : tlb_rdy) m_phase = 2;
         end else begin
            if (m_ica ? ica_done : tlb_done) begin
               m_rr = (m_entry + 1) % 4; m_cool = 1; m_phase = 0;
            end
         end
         m_ill = ill_n;
      end
   end

   always @(negedge ctcqctrlclk) begin : compare
      bit         x_iv, x_tv, x_busy;
      logic [3:0] x_c;
      x_iv   = cpurst_b && m_phase == 1 && m_legal && m_ica;
      x_tv   = cpurst_b && m_phase == 1 && m_legal && !m_ica;
      x_busy = cpurst_b && m_phase != 0;
      x_c    = 4'b0000;
      if (cpurst_b) begin
         if (m_ill >= 0) x_c = 4'(1 << m_ill);
         else if (m_phase == 2 && (m_ica ? ica_done : tlb_done)) x_c = 4'(1 << m_entry);
      end
      chk("m_ica_vld",   ica_vld,   x_iv);
      chk("m_ica_all",   ica_all,   x_iv && m_all);
      chk("m_ica_index", ica_index, x_iv ? m_index : 6'd0);
      chk("m_ica_ptag",  ica_ptag,  x_iv ? m_ptag : 28'd0);
      chk("m_tlb_vld",   tlb_vld,   x_tv);
      chk("m_tlb_type",  tlb_type,  x_tv ? m_type : 2'd0);
      chk("m_tlb_asid",  tlb_asid,  x_tv ? m_asid : 16'd0);
      chk("m_tlb_va",    tlb_va,    x_tv ? m_va : 27'd0);
      chk("m_cmplt",     cmplt,     x_c);
      chk("m_busy",      busy,      x_busy);
      for (int i = 0; i < 4; i++) if (cmplt[i]) svc.push_back(i);
   end

   // ---------------- stimulus helpers ----------------
   // One clock; an entry drops its pe_req after seeing its completion.
   task automatic tick();
      logic [3:0] c;
      #1;
      c = cmplt;
      @(posedge ctcqctrlclk);
      #1;
      pe_req = pe_req & ~c;
   endtask

   task automatic clr_entries();
      ica_all_f = '0; ica_line_f = '0; tlb_all_f = '0; tlb_va_all_f = '0;
      tlb_asid_all_f = '0; tlb_va_asid_f = '0;
      e_index = '0; e_ptag = '0; e_asid = '0; e_va = '0;
   endtask

   task automatic wait_vld(input bit tlb, input string nm);
      int n;
      n = 0;
      #1;
      while (!(tlb ? tlb_vld : ica_vld) && n < 20) begin
         tick();
         #1;
         n++;
      end
      chk(nm, n < 20, 1'b1);
   endtask

   task automatic serve_tlb(input int lat);
      wait_vld(1'b1, "rr_vld_timeout");
      tick();
      repeat (lat) tick();
      tlb_done = 1'b1;
      tick();
      tlb_done = 1'b0;
   endtask

   int exp_order[6] = '{0, 1, 2, 3, 0, 1};

   initial begin
      // reset state
      repeat (2) tick();
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_ica_vld", ica_vld, 1'b0);
      chk("rst_tlb_vld", tlb_vld, 1'b0);
      chk("rst_cmplt", cmplt, 4'b0000);
      cpurst_b = 1'b1;
      repeat (2) tick();

      // round robin over all four entries, then 0011 shows the pointer wrapped to 0
      svc.delete();
      tlb_all_f = 4'hF;
      tlb_rdy = 1'b1;
      pe_req = 4'hF;
      repeat (4) serve_tlb(1);
      pe_req = 4'b0011;
      repeat (2) serve_tlb(2);
      chk("rr_count", svc.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < svc.size()) chk("rr_order", svc[i], exp_order[i]);
      tlb_rdy = 1'b0;
      clr_entries();
      repeat (2) tick();

      // single icache line invalidate on entry 0
      e_index[5:0] = 6'h2A;
      e_ptag[27:0] = 28'hABCDEF1;
      ica_line_f = 4'b0001;
      ica_rdy = 1'b1;
      pe_req = 4'b0001;
      #1;
      chk("line_sel_busy", busy, 1'b0);
      tick(); #1;
      chk("line_vld", ica_vld, 1'b1);
      chk("line_all", ica_all, 1'b0);
      chk("line_index", ica_index, 6'h2A);
      chk("line_ptag", ica_ptag, 28'hABCDEF1);
      chk("line_tlb_vld", tlb_vld, 1'b0);
      tick(); #1;
      chk("line_vld_drop", ica_vld, 1'b0);
      chk("line_wait_busy", busy, 1'b1);
      tick();
      tick();
      ica_done = 1'b1;
      #1;
      chk("line_cmplt", cmplt, 4'b0001);
      tick();
      ica_done = 1'b0;
      #1;
      chk("line_idle_busy", busy, 1'b0);
      chk("line_idle_cmplt", cmplt, 4'b0000);
      ica_rdy = 1'b0;
      clr_entries();
      repeat (2) tick();

      // TLB va_asid on entry 2 with 5 cycles of backpressure
      e_asid[47:32] = 16'h00FF;
      e_va[80:54] = 27'h1234567;
      tlb_va_asid_f = 4'b0100;
      pe_req = 4'b0100;
      wait_vld(1'b1, "bp_vld_timeout");
      for (int i = 0; i < 6; i++) begin
         if (i == 5) tlb_rdy = 1'b1;
         #1;
         chk("bp_vld", tlb_vld, 1'b1);
         chk("bp_type", tlb_type, 2'b11);
         chk("bp_asid", tlb_asid, 16'h00FF);
         chk("bp_va", tlb_va, 27'h1234567);
         tick();
      end
      #1;
      chk("bp_vld_drop", tlb_vld, 1'b0);
      tlb_done = 1'b1;
      #1;
      chk("bp_cmplt", cmplt, 4'b0100);
      tick();
      tlb_done = 1'b0;
      tlb_rdy = 1'b0;
      clr_entries();
      repeat (2) tick();

      // illegal type on entry 2
      pe_req = 4'b0100;
      #1;
      chk("ill_c0_cmplt", cmplt, 4'b0000);
      tick(); #1;
      chk("ill_c1_cmplt", cmplt, 4'b0000);
      chk("ill_c1_busy", busy, 1'b1);
      chk("ill_c1_vld", {ica_vld, tlb_vld}, 2'b00);
      tick(); #1;
      chk("ill_c2_cmplt", cmplt, 4'b0100);
      chk("ill_c2_vld", {ica_vld, tlb_vld}, 2'b00);
      tick(); #1;
      chk("ill_c3_cmplt", cmplt, 4'b0000);
      tick(); #1;
      chk("ill_c4_busy", busy, 1'b0);
      repeat (2) tick();

      // stray icache done in IDLE
      ica_done = 1'b1;
      #1;
      chk("stray_cmplt", cmplt, 4'b0000);
      chk("stray_busy", busy, 1'b0);
      tick();
      ica_done = 1'b0;
      #1;
      chk("stray_busy_after", busy, 1'b0);

      // TLB done while waiting on an icache-all request from entry 3
      ica_all_f = 4'b1000;
      ica_rdy = 1'b1;
      pe_req = 4'b1000;
      wait_vld(1'b0, "mis_vld_timeout");
      chk("mis_all", ica_all, 1'b1);
      tick();
      tlb_done = 1'b1;
      #1;
      chk("mis_cmplt", cmplt, 4'b0000);
      tick();
      tlb_done = 1'b0;
      #1;
      chk("mis_busy", busy, 1'b1);
      ica_done = 1'b1;
      #1;
      chk("mis_good_cmplt", cmplt, 4'b1000);
      tick();
      ica_done = 1'b0;
      ica_rdy = 1'b0;
      clr_entries();
      repeat (2) tick();

      // reset asserted while waiting on entry 1
      ica_line_f = 4'b0010;
      ica_rdy = 1'b1;
      pe_req = 4'b0010;
      wait_vld(1'b0, "rst_vld_timeout");
      tick(); #1;
      chk("rstw_busy_pre", busy, 1'b1);
      cpurst_b = 1'b0;
      pe_req = 4'b0000;
      #1;
      chk("rstw_busy", busy, 1'b0);
      chk("rstw_vld", {ica_vld, tlb_vld}, 2'b00);
      chk("rstw_cmplt", cmplt, 4'b0000);
      tick();
      cpurst_b = 1'b1;
      tick();
      ica_done = 1'b1;
      #1;
      chk("rstw_late_done", cmplt, 4'b0000);
      chk("rstw_late_busy", busy, 1'b0);
      tick();
      ica_done = 1'b0;
      ica_rdy = 1'b0;
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
